wb_uart_loader: RTL and testbench
=================================

# wb_uart_loader

UART-to-Wishbone boot loader: receives a framed program image over a serial 8N1 line, assembles 16-bit words and writes them to the 16-bit block-RAM Wishbone slave as a single Wishbone master. It sits directly upstream of the program/data BRAM and fills it before the DCPU16 core is released from reset. It is write-only; it never issues read cycles.

## Interface
Parameters:
- CLK_DIV, 868: clock cycles per UART bit (100 MHz / 115200); legal range 8..65535.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  UART serial input, asynchronous to clk, idle high.
- adr  out  16  Wishbone address.
- dout  out  16  Wishbone write data (to slave din).
- cyc  out  1  Wishbone cycle.
- stb  out  1  Wishbone strobe.
- sel  out  2  byte selects, always 2'b11 during a cycle, else 2'b00.
- we  out  1  write enable, high during a cycle, else 0.
- ack  in  1  slave acknowledge.
- err  in  1  slave error.
- rty  in  1  slave retry.
- busy  out  1  high from header byte accepted until done/abort.
- done  out  1  one-cycle pulse on successful frame completion.
- error  out  1  sticky; cleared when the next 0xA5 header is accepted.

## Operation
- UART rx: 2-flop synchronizer on rxd. Falling edge in idle starts a frame; start bit re-checked at CLK_DIV/2 (if high, false start, back to idle). Data bits sampled every CLK_DIV cycles from mid-start, LSB first, 8 bits; stop bit sampled at mid-bit. Stop=0: framing error -> byte discarded, error set, parser aborts to P_IDLE.
- Frame: 0xA5, ADR_H, ADR_L, CNT_H, CNT_L, then CNT words each as DAT_H, DAT_L.
- Parser states: P_IDLE -> (byte==0xA5) P_ADRH -> P_ADRL -> P_CNTH -> P_CNTL -> (CNT==0: P_DONE; else P_DATH) -> P_DATL -> P_WRITE -> (remaining>0: P_DATH; else P_DONE) -> P_IDLE. Non-0xA5 bytes in P_IDLE ignored.
- P_WRITE: drive adr=current address, dout={DAT_H,DAT_L}, cyc=stb=we=1, sel=2'b11; hold until ack/err/rty sampled high.
- ack: address += 1 (mod 2^16, 16'hFFFF wraps to 16'h0000), remaining -= 1.
- err or rty (either, simultaneous with ack or not): treated as failure, no retry; error set, frame aborted to P_IDLE, busy cleared, no done.
- Byte completed while in P_WRITE: dropped, error set; frame continues (the write completes).
- done pulses in P_DONE only; error unaffected by done.

## Timing
- Reset (async): adr=0, dout=0, cyc=stb=we=0, sel=0, busy=0, done=0, error=0; parser P_IDLE, receiver idle. Reset mid-write drops cyc/stb immediately; partial frame discarded.
- Byte valid: internal 1-cycle strobe the cycle after the stop-bit sample.
- Word DAT_L strobe at cycle t -> cyc/stb/we/sel/adr/dout registered high at t+1.
- ack sampled high at cycle a -> cyc/stb/we/sel=0 at a+1; with the BRAM slave (ack one cycle after stb sampled) cyc is high exactly 2 cycles.
- Master outputs stay low at least 1 cycle between cycles (slave needs its done cycle); guaranteed because the next word needs >= 2 byte times.
- Last ack at cycle a -> done=1 at a+1 for one cycle, busy=0 at a+1. CNT=0: done the cycle after CNT_L strobe.
- busy rises the cycle after the 0xA5 strobe.

## Test plan
- Reset: rst high with rxd toggling -> all outputs 0; after release, no cyc for 100 idle bit times.
- Basic load (CLK_DIV=16): bytes A5 00 10 00 02 12 34 AB CD -> writes 16'h1234 @ 16'h0010, 16'hABCD @ 16'h0011, each cyc 2 cycles, sel=2'b11, done one pulse; BRAM readback matches.
- Wrap/zero count: A5 FF FF 00 02 00 01 00 02 -> writes @ 16'hFFFF then @ 16'h0000; A5 00 00 00 00 -> done with no cyc.
- Framing/garbage: 0x3C then A5 00 00 with bad stop bit on byte 3 -> 0x3C ignored, error=1, no writes; next A5 00 20 00 01 55 AA -> error cleared, 16'h55AA @ 16'h0020.
- Slave error: model asserts err instead of ack on 2nd of 3 words -> one write done, cyc drops next cycle, error=1, busy=0, no done.
- Reset mid-write: assert rst while cyc=1 -> cyc/stb/we low immediately; fresh frame after release loads correctly.

Source files
------------

// File: rtl/wb_uart_loader.sv
// wb_uart_loader
// UART (8N1) to Wishbone boot loader. Receives a framed program image
//   0xA5, ADR_H, ADR_L, CNT_H, CNT_L, {DAT_H, DAT_L} x CNT
// and writes each 16-bit word to a Wishbone slave as a single write-only master.
//
// Parameters:
//   CLK_DIV  clock cycles per UART bit (8..65535)
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   rxd      UART serial input (asynchronous, idle high)
//   adr      Wishbone address
//   dout     Wishbone write data
//   cyc/stb  Wishbone cycle / strobe
//   sel      byte selects (2'b11 during a cycle)
//   we       write enable (high during a cycle)
//   ack/err/rty  slave termination inputs
//   busy     frame in progress (header accepted until done/abort)
//   done     one-cycle pulse on successful frame completion
//   error    sticky error flag, cleared by the next accepted header
module wb_uart_loader #(
    parameter int CLK_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [15:0] adr,
    output logic [15:0] dout,
    output logic        cyc,
    output logic        stb,
    output logic [1:0]  sel,
    output logic        we,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] HALF_BIT = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [3:0] {
        P_IDLE,
        P_ADRH,
        P_ADRL,
        P_CNTH,
        P_CNTL,
        P_DATH,
        P_DATL,
        P_WRITE,
        P_DONE
    } p_state_t;

    rx_state_t   r_rx_state;
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_prev;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bits;
    logic [7:0]  r_rx_shift;
    logic        r_rx_valid;
    logic        r_rx_ferr;

    p_state_t    r_p_state;
    logic [15:0] r_adr;
    logic [15:0] r_dout;
    logic        r_cyc;
    logic        r_stb;
    logic [1:0]  r_sel;
    logic        r_we;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_rem;
    logic [7:0]  r_cnt_h;
    logic [7:0]  r_dat_h;

    logic        w_term_fail;

    assign w_term_fail = err | rty;

    assign adr   = r_adr;
    assign dout  = r_dout;
    assign cyc   = r_cyc;
    assign stb   = r_stb;
    assign sel   = r_sel;
    assign we    = r_we;
    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;

    // UART receiver: synchronizer, start-bit validation, 8 data bits, stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= R_IDLE;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_cnt   <= 16'h0000;
            r_rx_bits  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    r_rx_cnt <= 16'h0000;
                    // Only a genuine high-to-low transition starts a frame, so a
                    // line left low after a bad stop bit does not retrigger.
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_state <= R_START;
                    end else begin
                        r_rx_state <= R_IDLE;
                    end
                end
                R_START: begin
                    if (r_rx_cnt == HALF_BIT) begin
                        r_rx_cnt  <= 16'h0000;
                        r_rx_bits <= 3'd0;
                        if (!r_rx_s2) begin
                            r_rx_state <= R_DATA;
                        end else begin
                            r_rx_state <= R_IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'h0001;
                    end
                end
                R_DATA: begin
                    if (r_rx_cnt == FULL_BIT) begin
                        r_rx_cnt   <= 16'h0000;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bits == 3'd7) begin
                            r_rx_state <= R_STOP;
                        end else begin
                            r_rx_bits <= r_rx_bits + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'h0001;
                    end
                end
                R_STOP: begin
                    if (r_rx_cnt == FULL_BIT) begin
                        r_rx_cnt   <= 16'h0000;
                        r_rx_state <= R_IDLE;
                        r_rx_valid <= r_rx_s2;
                        r_rx_ferr  <= ~r_rx_s2;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'h0001;
                    end
                end
                default: begin
                    r_rx_state <= R_IDLE;
                end
            endcase
        end
    end

    // Frame parser and Wishbone master with registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_state <= P_IDLE;
            r_adr     <= 16'h0000;
            r_dout    <= 16'h0000;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_sel     <= 2'b00;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_rem     <= 16'h0000;
            r_cnt_h   <= 8'h00;
            r_dat_h   <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_p_state)
                P_IDLE: begin
                    if (r_rx_valid && (r_rx_shift == 8'hA5)) begin
                        r_busy    <= 1'b1;
                        r_error   <= 1'b0;
                        r_p_state <= P_ADRH;
                    end
                end
                P_ADRH: begin
                    if (r_rx_valid) begin
                        r_adr[15:8] <= r_rx_shift;
                        r_p_state   <= P_ADRL;
                    end
                end
                P_ADRL: begin
                    if (r_rx_valid) begin
                        r_adr[7:0] <= r_rx_shift;
                        r_p_state  <= P_CNTH;
                    end
                end
                P_CNTH: begin
                    if (r_rx_valid) begin
                        r_cnt_h   <= r_rx_shift;
                        r_p_state <= P_CNTL;
                    end
                end
                P_CNTL: begin
                    if (r_rx_valid) begin
                        // Zero-length frame completes right away; done is raised
                        // here so it appears the cycle after the CNT_L strobe.
                        if ({r_cnt_h, r_rx_shift} == 16'h0000) begin
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_p_state <= P_DONE;
                        end else begin
                            r_rem     <= {r_cnt_h, r_rx_shift};
                            r_p_state <= P_DATH;
                        end
                    end
                end
                P_DATH: begin
                    if (r_rx_valid) begin
                        r_dat_h   <= r_rx_shift;
                        r_p_state <= P_DATL;
                    end
                end
                P_DATL: begin
                    if (r_rx_valid) begin
                        r_dout    <= {r_dat_h, r_rx_shift};
                        r_cyc     <= 1'b1;
                        r_stb     <= 1'b1;
                        r_we      <= 1'b1;
                        r_sel     <= 2'b11;
                        r_p_state <= P_WRITE;
                    end
                end
                P_WRITE: begin
                    // A byte arriving mid-write cannot be buffered: drop it.
                    if (r_rx_valid) begin
                        r_error <= 1'b1;
                    end
                    if (w_term_fail) begin
                        r_cyc     <= 1'b0;
                        r_stb     <= 1'b0;
                        r_we      <= 1'b0;
                        r_sel     <= 2'b00;
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_p_state <= P_IDLE;
                    end else if (ack) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        r_sel <= 2'b00;
                        r_adr <= r_adr + 16'h0001;
                        r_rem <= r_rem - 16'h0001;
                        if (r_rem == 16'h0001) begin
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_p_state <= P_DONE;
                        end else begin
                            r_p_state <= P_DATH;
                        end
                    end
                end
                P_DONE: begin
                    r_p_state <= P_IDLE;
                end
                default: begin
                    r_p_state <= P_IDLE;
                end
            endcase
            // Framing error aborts the frame, except during a write, which must
            // be allowed to terminate cleanly on the bus.
            if (r_rx_ferr) begin
                r_error <= 1'b1;
                if (r_p_state != P_WRITE) begin
                    r_busy    <= 1'b0;
                    r_p_state <= P_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_uart_loader.sv
module tb_wb_uart_loader;

    localparam int DIV = 16;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] adr;
    logic [15:0] dout;
    logic        cyc;
    logic        stb;
    logic [1:0]  sel;
    logic        we;
    logic        ack = 1'b0;
    logic        s_err = 1'b0;
    logic        rty = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    // slave / monitor state
    int          wcount = 0;
    int          err_on = 0;
    logic        slave_off = 1'b0;
    logic [15:0] mem [int];
    logic [31:0] exp_q [$];
    int          done_cnt = 0;
    int          cyc_starts = 0;
    int          cyc_len = 0;
    logic        cyc_q = 1'b0;

    wb_uart_loader #(.CLK_DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .adr   (adr),
        .dout  (dout),
        .cyc   (cyc),
        .stb   (stb),
        .sel   (sel),
        .we    (we),
        .ack   (ack),
        .err   (s_err),
        .rty   (rty),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // BRAM-like slave: answers one cycle after it samples stb
    always @(posedge clk) begin
        ack   <= 1'b0;
        s_err <= 1'b0;
        if (cyc && stb && !ack && !s_err && !slave_off && !rst) begin
            wcount <= wcount + 1;
            if (wcount + 1 == err_on) s_err <= 1'b1;
            else                      ack   <= 1'b1;
        end
    end

    // Bus monitor and scoreboard, sampled away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            cyc_len = 0;
            cyc_q   = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (cyc && !cyc_q) cyc_starts++;
            if (cyc) begin
                cyc_len++;
            end else if (cyc_len != 0) begin
                chk("cyc_len", 32'(cyc_len), 32'd2);
                cyc_len = 0;
            end
            if (cyc && (ack || s_err)) begin
                chk("sel_we", {29'd0, sel, we}, {29'd0, 2'b11, 1'b1});
            end
            if (cyc && ack) begin
                mem[int'(adr)] = dout;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {adr, dout}, 32'hxxxx_xxxx);
                end else begin
                    chk("write_adr_dat", {adr, dout}, exp_q.pop_front());
                end
            end
            cyc_q = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_seq(input byte_q_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    int d0;
    int c0;

    initial begin
        // ---- reset with rxd toggling ----
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rxd = ~rxd;
        end
        chk("rst_adr", {16'd0, adr}, 32'd0);
        chk("rst_dout", {16'd0, dout}, 32'd0);
        chk("rst_bus", {27'd0, cyc, stb, we, sel}, 32'd0);
        chk("rst_status", {29'd0, busy, done, error}, 32'd0);
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100 * DIV) @(negedge clk);
        chk("idle_no_cyc", 32'(cyc_starts), 32'd0);

        // ---- basic load ----
        exp_q.push_back({16'h0010, 16'h1234});
        exp_q.push_back({16'h0011, 16'hABCD});
        d0 = done_cnt;
        send_byte(8'hA5, 1'b1);
        chk("busy_after_hdr", {31'd0, busy}, 32'd1);
        send_seq('{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
        repeat (40) @(negedge clk);
        chk("basic_done", 32'(done_cnt - d0), 32'd1);
        chk("basic_status", {29'd0, busy, done, error}, 32'd0);
        chk("basic_q_empty", 32'(exp_q.size()), 32'd0);
        chk("basic_mem0", {16'd0, mem[16'h0010]}, 32'h1234);
        chk("basic_mem1", {16'd0, mem[16'h0011]}, 32'hABCD);

        // ---- address wrap ----
        exp_q.push_back({16'hFFFF, 16'h0001});
        exp_q.push_back({16'h0000, 16'h0002});
        d0 = done_cnt;
        send_seq('{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02});
        repeat (40) @(negedge clk);
        chk("wrap_done", 32'(done_cnt - d0), 32'd1);
        chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);
        chk("wrap_mem_ffff", {16'd0, mem[16'hFFFF]}, 32'h0001);
        chk("wrap_mem_0000", {16'd0, mem[16'h0000]}, 32'h0002);

        // ---- zero count ----
        d0 = done_cnt;
        c0 = cyc_starts;
        send_seq('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00});
        repeat (40) @(negedge clk);
        chk("zero_done", 32'(done_cnt - d0), 32'd1);
        chk("zero_no_cyc", 32'(cyc_starts - c0), 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd0);

        // ---- garbage + framing error ----
        d0 = done_cnt;
        c0 = cyc_starts;
        send_seq('{8'h3C, 8'hA5, 8'h00});
        send_byte(8'h00, 1'b0);
        repeat (40) @(negedge clk);
        chk("ferr_error", {31'd0, error}, 32'd1);
        chk("ferr_busy", {31'd0, busy}, 32'd0);
        chk("ferr_no_cyc", 32'(cyc_starts - c0), 32'd0);
        chk("ferr_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q.push_back({16'h0020, 16'h55AA});
        send_byte(8'hA5, 1'b1);
        chk("hdr_clears_error", {30'd0, busy, error}, {30'd0, 2'b10});
        send_seq('{8'h00, 8'h20, 8'h00, 8'h01, 8'h55, 8'hAA});
        repeat (40) @(negedge clk);
        chk("recover_done", 32'(done_cnt - d0), 32'd1);
        chk("recover_mem", {16'd0, mem[16'h0020]}, 32'h55AA);

        // ---- slave error on 2nd of 3 words ----
        err_on = wcount + 2;
        exp_q.push_back({16'h0030, 16'h1111});
        d0 = done_cnt;
        send_seq('{8'hA5, 8'h00, 8'h30, 8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33});
        repeat (40) @(negedge clk);
        chk("serr_status", {29'd0, busy, done, error}, 32'd1);
        chk("serr_no_done", 32'(done_cnt - d0), 32'd0);
        chk("serr_q_empty", 32'(exp_q.size()), 32'd0);
        chk("serr_mem0", {16'd0, mem[16'h0030]}, 32'h1111);
        chk("serr_no_mem1", {31'd0, mem.exists(16'h0031)}, 32'd0);
        err_on = 0;

        // ---- reset mid-write ----
        slave_off = 1'b1;
        send_seq('{8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'h77, 8'h88});
        chk("held_cyc", {31'd0, cyc}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_bus", {27'd0, cyc, stb, we, sel}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        slave_off = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.push_back({16'h0040, 16'h9ABC});
        d0 = done_cnt;
        send_seq('{8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'h9A, 8'hBC});
        repeat (40) @(negedge clk);
        chk("post_rst_done", 32'(done_cnt - d0), 32'd1);
        chk("post_rst_mem", {16'd0, mem[16'h0040]}, 32'h9ABC);
        chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
